// File: rtl/sumador_multiciclo.sv
`default_nettype none
// ============================================================================
// sumador_multiciclo : WIDTH-bit adder evaluated CHUNK bits per clock with a
//                      registered carry; optional SUMADOR_OVF_EN adds 'ovf'.
// Revision 1.0
// ============================================================================
module sumador_multiciclo #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
`ifdef SUMADOR_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("sumador_multiciclo: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               cout_q, cout_d;
`ifdef SUMADOR_OVF_EN
    logic               ovf_q, ovf_d;
    logic               msb_cin;
`endif

    logic [IDX_W-1:0]   base;
    logic [CHUNK-1:0]   sl_a;
    logic [CHUNK-1:0]   sl_b;
    logic [CHUNK:0]     sl_sum;

    // Current chunk of both operands and its carry-extended sum.
    always_comb begin
        base   = IDX_W'(cnt_q) * IDX_W'(CHUNK);
        sl_a   = opa_q[base +: CHUNK];
        sl_b   = opb_q[base +: CHUNK];
        sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + (CHUNK+1)'(carry_q);
    end

`ifdef SUMADOR_OVF_EN
    // Carry into the top bit, recovered from the top bit's sum equation.
    assign msb_cin = sl_a[CHUNK-1] ^ sl_b[CHUNK-1] ^ sl_sum[CHUNK-1];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cout_d    = cout_q;
`ifdef SUMADOR_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d   = b1;
                    opb_d   = b2;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d[base +: CHUNK] = sl_sum[CHUNK-1:0];
                carry_d              = sl_sum[CHUNK];
                cnt_d                = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // acc_d already holds the slice written this cycle.
                    q_d     = acc_d;
                    cout_d  = sl_sum[CHUNK];
`ifdef SUMADOR_OVF_EN
                    ovf_d   = msb_cin ^ sl_sum[CHUNK];
`endif
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SUMADOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
`ifdef SUMADOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign q    = q_q;
    assign cout = cout_q;
`ifdef SUMADOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sumador_multiciclo.sv
`default_nettype none
// tb_sumador_multiciclo : scoreboard bench, directed + random operands against
// an arithmetic reference; a second instance covers CHUNK == WIDTH.
module tb_sumador_multiciclo;

    localparam int W   = 32;
    localparam int C   = 8;
    localparam int NCH = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] b1 = '0;
    logic [W-1:0] b2 = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] q;
    logic         cout;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [W-1:0] b1_1 = '0;
    logic [W-1:0] b2_1 = '0;
    logic         cin1 = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b1;
    logic [W-1:0] q1;
    logic         cout1;
`ifdef SUMADOR_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    always #5 clk = ~clk;

    sumador_multiciclo #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b1        (b1),
        .b2        (b2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
`ifdef SUMADOR_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    sumador_multiciclo #(.WIDTH(W), .CHUNK(W)) u_dut_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .b1        (b1_1),
        .b2        (b2_1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .q         (q1),
`ifdef SUMADOR_OVF_EN
        .ovf       (ovf1),
`endif
        .cout      (cout1)
    );

    typedef struct {
        logic [W-1:0] q;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   bp_until = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: unsigned sum for q/cout, signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] bb,
                                   input logic ci, input int t);
        exp_t        e;
        logic [W:0]  s;
        longint      ss;
        longint      lim;
        s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        ss  = longint'($signed(a)) + longint'($signed(bb)) + longint'(ci);
        lim = 64'sd1 <<< (W - 1);
        e.q = s[W-1:0];
        e.c = s[W];
        e.o = (ss >= lim) || (ss < -lim);
        e.t = t;
        return e;
    endfunction

    // Holds in_valid high with junk operands until in_ready, then presents the real ones.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] bb, input logic ci);
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            b1  = W'($urandom);
            b2  = W'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1 within 200 cycles", in_ready);
        end else begin
            b1 = a;
            b2 = bb;
            cin = ci;
            exp_q.push_back(model(a, bb, ci, cyc + 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
        b1  = W'($urandom);
        b2  = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic full_chunk(input logic [W-1:0] a, input logic [W-1:0] bb, input logic ci);
        exp_t e;
        e = model(a, bb, ci, 0);
        chk("full_in_ready", {63'b0, in_ready1}, 64'd1);
        b1_1 = a;
        b2_1 = bb;
        cin1 = ci;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        b1_1 = W'($urandom);
        chk("full_valid_early", {63'b0, out_valid1}, 64'd0);
        @(negedge clk);
        chk("full_valid_t1", {63'b0, out_valid1}, 64'd1);
        chk("full_q", {32'b0, q1}, {32'b0, e.q});
        chk("full_cout", {63'b0, cout1}, {63'b0, e.c});
`ifdef SUMADOR_OVF_EN
        chk("full_ovf", {63'b0, ovf1}, {63'b0, e.o});
`endif
        @(negedge clk);
        chk("full_release", {63'b0, out_valid1}, 64'd0);
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = '1;
            2:       v = W'(1) << $urandom_range(0, W - 1);
            3:       v = ~(W'(1) << $urandom_range(0, W - 1));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            out_ready = (cyc < bp_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor: pops one expectation per result presentation.
    initial begin : monitor
        bit   seen = 1'b0;
        bit   have_last = 1'b0;
        bit   prev_hs = 1'b0;
        exp_t last;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 1'b0;
                have_last = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) chk("leave_done", {63'b0, out_valid}, 64'd0);
                if (out_valid) begin
                    chk("in_ready_in_done", {63'b0, in_ready}, 64'd0);
                    if (!seen) begin
                        seen = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: q=%0h with no pending operation", q);
                        end else begin
                            last = exp_q.pop_front();
                            have_last = 1'b1;
                            chk("q", {32'b0, q}, {32'b0, last.q});
                            chk("cout", {63'b0, cout}, {63'b0, last.c});
                            chk("latency", 64'(cyc - last.t), 64'(NCH));
`ifdef SUMADOR_OVF_EN
                            chk("ovf", {63'b0, ovf}, {63'b0, last.o});
`endif
                        end
                    end else if (have_last) begin
                        chk("q_hold", {32'b0, q}, {32'b0, last.q});
                        chk("cout_hold", {63'b0, cout}, {63'b0, last.c});
                    end
                    prev_hs = out_ready;
                end else begin
                    seen = 1'b0;
                    prev_hs = 1'b0;
                    if (have_last) begin
                        chk("q_idle", {32'b0, q}, {32'b0, last.q});
                        chk("cout_idle", {63'b0, cout}, {63'b0, last.c});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        chk("rst_q", {32'b0, q}, 64'd0);
        chk("rst_cout", {63'b0, cout}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        full_chunk(32'h0000_0001, 32'h0000_0001, 1'b0);
        full_chunk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        full_chunk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        send(32'h00FF_FFFF, 32'h0000_0001, 1'b0);

        // Abandon an operation two chunks in; last result is non-zero here.
        send(32'h0000_00AB, 32'h0000_00CD, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_q", {32'b0, q}, 64'd0);
        chk("midrst_cout", {63'b0, cout}, 64'd0);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h0000_0010, 32'h0000_0020, 1'b0);

        bp_until = cyc + 20;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

        for (int i = 0; i < 40; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d out_valid=%0b expected 0/0", exp_q.size(), out_valid);
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sumador_multiciclo.md
Name: sumador_multiciclo

Overview:
- Parametrised multi-cycle adder: computes q = b1 + b2 + cin over WIDTH bits, CHUNK bits per clock, with one registered carry between chunks.
- Successor to the 32-bit single-cycle ripple adder, for wide datapaths where a full-width carry chain misses timing.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- b1  input  WIDTH  operand A.
- b2  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- q  output  WIDTH  sum, registered.
- cout  output  1  carry out of MSB, registered.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; q=0, cout=0, out_valid=0; chunk counter=0; carry register=0. in_ready=1 once reset is released.
- Reset mid-operation: the operation is abandoned, all state clears as above, and no partial result is ever flagged valid.
- States and transitions:
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, capture b1, b2, cin; set cnt=0, carry=cin; go to CALC.
  - CALC: in_ready=0, out_valid=0. Each cycle, {c, s} = b1[cnt*CHUNK +: CHUNK] + b2[same] + carry, all widths CHUNK+1. Store s into the internal accumulator slice, carry <= c, cnt++. When cnt==NCHUNK-1, load q from the accumulator (including the current slice), cout <= c, and go to DONE.
  - DONE: out_valid=1, in_ready=0. q and cout are held stable. On an edge with out_ready=1, go to IDLE.
- Latency: if operands are accepted at edge T, out_valid rises after edge T+NCHUNK. When CHUNK==WIDTH, CALC lasts one cycle.
- Throughput: one operation per NCHUNK+2 cycles (minimum, with out_ready held high). in_ready is low throughout CALC and DONE; in_valid and operands are ignored there.
- q/cout change only on the CALC->DONE transition and on reset. After a handshake they keep their last value in IDLE, but out_valid=0.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true (WIDTH+1)th bit. Operands are captured at acceptance; later changes on b1/b2/cin have no effect.
- Backpressure: out_ready may stay low indefinitely; the block remains in DONE.
- out_ready is a don't-care outside DONE.

Optional Feature:
- Macro SUMADOR_OVF_EN.
- Defined: adds output port `ovf` (output, 1 bit) = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow. It is registered with q/cout on the CALC->DONE transition, reset to 0, and held in DONE.
- Not defined: no `ovf` port and no overflow logic.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=32, CHUNK=8; b1=0x00000001, b2=0x00000001, cin=0 accepted at edge T -> out_valid high after edge T+4; q=0x00000002, cout=0.
- b1=0xFFFFFFFF, b2=0x00000000, cin=1 -> q=0x00000000, cout=1 (carry crosses all 4 chunk boundaries).
- b1=0x000000FF, b2=0x00000001, cin=0 -> q=0x00000100, cout=0. Also b1=0x00FFFFFF, b2=0x1 -> q=0x01000000.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and q stay stable. Drive in_valid=1, b1=0x3 during CALC/DONE -> in_ready=0 and the operand is not captured; it is accepted only after returning to IDLE.
- Assert rst_n=0 for one cycle during CALC (cnt=2) -> q=0, cout=0, out_valid=0 immediately. Then b1=0x10, b2=0x20 -> q=0x30.
- With SUMADOR_OVF_EN:
  - 0x7FFFFFFF+0x1 -> q=0x80000000, ovf=1, cout=0.
  - 0x80000000+0x80000000 -> q=0, cout=1, ovf=1.
  - 0xFFFFFFFF+0x1 -> ovf=0, cout=1.
- Also rerun test 1 with CHUNK=32 -> out_valid after edge T+1.
